// File: rtl/fifo_stream_out.sv
// Read-side adapter for a registered-read FIFO: issues reads against a credit count
// and re-presents the returned words as a valid/ready stream through a small ring buffer.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fifo_empty,
  output logic                               fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]              fifo_rd_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  generate
    if (BUF_DEPTH < 3) begin : g_depth_chk
      $fatal(1, "fifo_stream_out: BUF_DEPTH must be at least 3 for full throughput");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  inflight;
  logic                  capture;
  logic                  pop;
  logic [CNT_W:0]        credits_used;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A read in flight already owns a buffer slot, so it is counted as a spent credit.
  assign credits_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en   = !rst && !fifo_empty && (credits_used < DEPTH_EXT);

  assign capture   = inflight;
  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem[head] : '0;
  assign buf_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (capture) tail <= ptr_next(tail);
      if (pop)     head <= ptr_next(head);
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (capture) mem[tail] <= fifo_rd_data;
  end

`ifndef SYNTHESIS
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    stall_q <= !rst && m_valid && !m_ready;
    data_q  <= m_data;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (credits_used <= DEPTH_EXT)
        else $error("fifo_stream_out: buffer plus in-flight exceeds depth");
      assert (!(capture && (count == DEPTH_CNT)))
        else $error("fifo_stream_out: capture into a full buffer");
      assert (!stall_q || (m_data == data_q))
        else $error("fifo_stream_out: m_data changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural registered-read FIFO upstream, scoreboard
// of pushed words checked by an independent output monitor, plus directed timing checks.
module tb_fifo_stream_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] buf_count;

  logic [7:0] fifo_mem [256];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic [7:0] sb [$];
  int         exp_rd = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  fifo_stream_out #(.DATA_WIDTH(8), .BUF_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .buf_count    (buf_count)
  );

  // Upstream FIFO model: data is registered one cycle after the strobe.
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_idx] = d;
    wr_idx++;
    sb.push_back(d);
  endtask

  initial begin
    int beats, first, last, pulses, pushed, found;
    rst     = 1'b1;
    m_ready = 1'b1;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst) begin
            // Words read from the FIFO before a reset are discarded by the DUT.
            exp_rd = rd_idx;
          end else if (m_valid && m_ready) begin
            if (exp_rd >= sb.size()) begin
              checks++;
              failures++;
              $display("FAIL beat_unexpected: got %0h expected no beat", m_data);
            end else begin
              chk("beat_data", m_data, sb[exp_rd]);
              exp_rd++;
            end
          end
        end
      end
      begin : stimulus
        // Reset with a non-empty FIFO, then streaming of 0x01..0x10.
        for (int i = 1; i <= 16; i++) push(8'(i));
        repeat (3) begin
          tick();
          chk("rst_rd_en", fifo_rd_en, 0);
          chk("rst_valid", m_valid, 0);
          chk("rst_data", m_data, 0);
          chk("rst_count", buf_count, 0);
        end
        rst = 1'b0;
        #1;
        chk("first_rd_en", fifo_rd_en, 1);
        tick();
        chk("lat_n1_valid", m_valid, 0);
        tick();
        chk("lat_n2_valid", m_valid, 1);
        beats = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 30; c++) begin
          if (m_valid) begin
            if (first < 0) first = c;
            last = c;
            beats++;
            if (beats == 6) begin
              chk("cap_pop_count", buf_count, 1);
              chk("cap_pop_head", m_data, 8'h06);
            end
          end
          tick();
        end
        chk("stream_first", first, 0);
        chk("stream_beats", beats, 16);
        chk("stream_no_bubble", last - first + 1, 16);
        chk("stream_all", exp_rd, 16);

        // Full backpressure with 8 words queued.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        #1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
          if (fifo_rd_en) pulses++;
          if (c == 6) chk("bp_hold_data", m_data, 8'h21);
          tick();
        end
        chk("bp_pulses", pulses, 4);
        chk("bp_count", buf_count, 4);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'h21);
        m_ready = 1'b1;
        #1;
        chk("bp_no_comb_path", fifo_rd_en, 0);
        tick();
        chk("bp_resume", fifo_rd_en, 1);
        repeat (20) tick();
        chk("bp_all", exp_rd, 24);
        chk("bp_drained", buf_count, 0);

        // 100 words with random stalls and random refill.
        pushed = 0;
        for (int c = 0; c < 3000; c++) begin
          m_ready = 1'($urandom_range(0, 1));
          if (pushed < 100 && $urandom_range(0, 2) != 0) begin
            push(8'(pushed * 37 + 5));
            pushed++;
          end
          chk("rand_count_bound", 32'(buf_count <= 3'd4), 1);
          tick();
          if (pushed == 100 && exp_rd == sb.size()) break;
        end
        m_ready = 1'b1;
        chk("rand_pushed", pushed, 100);
        chk("rand_all", exp_rd, 124);

        // Reset while buffer holds 3 words and a read is in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h41 + i));
        found = 0;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (buf_count == 3'd3) begin
            found = 1;
            break;
          end
        end
        chk("mid_found", found, 1);
        rst = 1'b1;
        tick();
        chk("mid_count", buf_count, 0);
        chk("mid_valid", m_valid, 0);
        chk("mid_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        #1;
        tick();
        chk("mid_no_capture", buf_count, 0);
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
          if (m_valid) break;
          tick();
        end
        chk("mid_first_word", m_data, 8'h45);
        repeat (12) tick();
        chk("mid_all", exp_rd, 132);
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
